// File: rtl/a1csa_pkg.sv
// Shared constants for the segmented decrement pipeline.
package a1csa_pkg;

    localparam int unsigned A1CSA_SEG   = 3;
    localparam int unsigned A1CSA_WIDTH = 12;
    localparam int unsigned A1CSA_NSEG  = A1CSA_WIDTH / A1CSA_SEG;

endpackage

// File: rtl/rb_dec3.sv
// Conditional decrement of one 3-bit segment; each bit toggles when all lower bits are zero.
module rb_dec3
    import a1csa_pkg::*;
(
    input  logic                 sel,
    input  logic [A1CSA_SEG-1:0] seg,
    output logic [A1CSA_SEG-1:0] dec
);

    assign dec[0] = seg[0] ^ sel;
    assign dec[1] = seg[1] ^ (sel & ~seg[0]);
    assign dec[2] = seg[2] ^ (sel & ~seg[0] & ~seg[1]);

endmodule

// File: rtl/a1csa_dec_pipe.sv
// Two-stage valid/ready pipeline computing (x - sel) mod 2^WIDTH with a segmented borrow chain.
module a1csa_dec_pipe
    import a1csa_pkg::*;
#(
    parameter int unsigned WIDTH = A1CSA_WIDTH,
    parameter int unsigned SEG   = A1CSA_SEG
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic             sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             borrow_out
);

    localparam int unsigned NSEG = WIDTH / SEG;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_x;
    logic             s1_sel;
    logic [NSEG-1:0]  s1_zero;
    logic             s2_valid;
    logic [WIDTH-1:0] s2_result;
    logic             s2_borrow;

    logic             s1_load;
    logic             s2_load;
    logic [NSEG-1:0]  seg_zero;
    logic [NSEG-1:0]  seg_bsel;
    logic [WIDTH-1:0] dec_x;
    logic             chain;

    assign s2_load  = !s2_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = s1_load;

    always_comb begin
        seg_zero = '0;
        for (int k = 0; k < NSEG; k++) begin
            seg_zero[k] = (x[k*SEG +: SEG] == '0);
        end
    end

    // A segment borrows only when sel is set and every segment below it is zero.
    always_comb begin
        seg_bsel = '0;
        chain    = s1_sel;
        for (int k = 0; k < NSEG; k++) begin
            seg_bsel[k] = chain;
            chain       = chain & s1_zero[k];
        end
    end

    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        rb_dec3 u_dec (
            .sel (seg_bsel[k]),
            .seg (s1_x[k*SEG +: SEG]),
            .dec (dec_x[k*SEG +: SEG])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            s2_result <= '0;
            s2_borrow <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_valid <= in_valid;
            end
            if (s2_load) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_result <= dec_x;
                    s2_borrow <= s1_sel & (&s1_zero);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (s1_load && in_valid) begin
            s1_x    <= x;
            s1_sel  <= sel;
            s1_zero <= seg_zero;
        end
    end

    // Empty-stage data never reaches the outputs.
    assign out_valid  = s2_valid;
    assign result     = s2_valid ? s2_result : '0;
    assign borrow_out = s2_valid & s2_borrow;

endmodule

// File: tb/tb_a1csa_dec_pipe.sv
// Self-checking bench: directed cases then randomized traffic against a queue-based reference.
module tb_a1csa_dec_pipe;

    localparam int unsigned W = 12;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] x;
    logic         sel;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         borrow_out;

    a1csa_dec_pipe #(
        .WIDTH (W),
        .SEG   (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .x          (x),
        .sel        (sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .borrow_out (borrow_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic         bor;
        int           rdy;
    } exp_t;

    exp_t q[$];
    int   nvec;
    int   nerr;
    int   cyc;
    int   nout;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check against the model, advance the model at the edge.
    task automatic step(input logic r, input logic iv, input logic [W-1:0] ix, input logic is,
                        input logic ordy, input logic zchk);
        logic exp_ov;
        logic exp_ir;
        logic in_fire;
        logic out_fire;
        exp_t e;
        rst       = r;
        in_valid  = iv;
        x         = ix;
        sel       = is;
        out_ready = ordy;
        #1;
        exp_ov = (q.size() > 0) && (cyc >= q[0].rdy);
        exp_ir = (q.size() < 2) || ordy;
        if (!r) begin
            check("in_ready", {31'b0, in_ready}, {31'b0, exp_ir});
            check("out_valid", {31'b0, out_valid}, {31'b0, exp_ov});
            if (exp_ov) begin
                check("result", {20'b0, result}, {20'b0, q[0].res});
                check("borrow_out", {31'b0, borrow_out}, {31'b0, q[0].bor});
            end
            if (zchk) begin
                check("reset_result", {20'b0, result}, 32'h0);
                check("reset_borrow", {31'b0, borrow_out}, 32'h0);
            end
        end
        in_fire  = !r && iv && exp_ir;
        out_fire = !r && exp_ov && ordy;
        @(posedge clk);
        if (r) begin
            q.delete();
        end else begin
            if (out_fire) begin
                void'(q.pop_front());
                nout++;
            end
            if (in_fire) begin
                e.res = W'((int'(ix) - int'(is)) & 32'hFFF);
                e.bor = is && (ix == '0);
                e.rdy = cyc + 2;
                q.push_back(e);
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    function automatic logic [W-1:0] rand_x();
        case ($urandom % 4)
            0:       rand_x = '0;
            1:       rand_x = W'(1) << $urandom_range(0, W - 1);
            default: rand_x = W'($urandom_range(0, 4095));
        endcase
    endfunction

    initial begin
        int budget;
        nvec = 0;
        nerr = 0;
        cyc  = 0;
        nout = 0;

        step(1, 0, '0, 0, 1, 0);
        step(1, 0, '0, 0, 1, 0);
        step(0, 0, '0, 0, 1, 1);

        // Single operands with full latency visible.
        step(0, 1, 12'h010, 1, 1, 0);
        step(0, 0, '0, 0, 1, 0);
        step(0, 0, '0, 0, 1, 0);
        step(0, 1, 12'h000, 1, 1, 0);
        step(0, 1, 12'hABC, 0, 1, 0);
        step(0, 1, 12'h200, 1, 1, 0);
        step(0, 0, '0, 0, 1, 0);
        step(0, 0, '0, 0, 1, 0);
        step(0, 0, '0, 0, 1, 0);

        // Back-to-back stream with a two-cycle consumer stall.
        step(0, 1, 12'h005, 1, 1, 0);
        step(0, 1, 12'h040, 1, 1, 0);
        step(0, 1, 12'h800, 1, 0, 0);
        check("stall_in_ready", {31'b0, in_ready}, 32'h0);
        step(0, 1, 12'h800, 1, 0, 0);
        step(0, 1, 12'h800, 1, 1, 0);
        step(0, 0, '0, 0, 1, 0);
        step(0, 0, '0, 0, 1, 0);
        step(0, 0, '0, 0, 1, 0);
        check("stream_drained", q.size(), 32'h0);

        // Fill the pipe, then reset it mid-stream.
        step(0, 1, 12'h123, 1, 0, 0);
        step(0, 1, 12'h456, 0, 0, 0);
        step(0, 0, '0, 0, 0, 0);
        step(1, 1, 12'h777, 1, 1, 0);
        step(0, 0, '0, 0, 1, 1);
        step(0, 0, '0, 0, 1, 0);
        step(0, 0, '0, 0, 1, 0);

        // Random traffic until 10k results have been consumed.
        nout   = 0;
        budget = 60000;
        while (nout < 10000 && budget > 0) begin
            step(0, ($urandom % 4) != 0, rand_x(), $urandom_range(0, 1), ($urandom % 4) != 0, 0);
            budget--;
        end
        check("random_budget", {31'b0, budget > 0}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, '0, 0, 1, 0);
        end
        check("random_drained", q.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/a1csa_dec_pipe.md
A1CSA_DEC_PIPE -- requirements
Module: a1csa_dec_pipe

Interface
REQ-001 Parameter WIDTH, default 12; operand width; SHALL be a positive multiple of 3.
REQ-002 Parameter SEG, default 3; segment width; fixed at 3.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 in_valid  input  1  high when x and sel hold a valid operand.
REQ-006 in_ready  output  1  high when the block accepts an operand this cycle.
REQ-007 x  input  WIDTH  operand.
REQ-008 sel  input  1  1 = subtract one from x; 0 = pass x through.
REQ-009 out_valid  output  1  high when result and borrow_out are valid.
REQ-010 out_ready  input  1  high when the consumer accepts the result this cycle.
REQ-011 result  output  WIDTH  (x - sel) mod 2^WIDTH.
REQ-012 borrow_out  output  1  sel & (x == 0).

Function
REQ-013 An input transfer SHALL occur when in_valid and in_ready are both high at a rising edge; an output transfer SHALL occur when out_valid and out_ready are both high.
REQ-014 The block SHALL be a 2-stage pipeline (S1, S2) with one valid flag per stage; latency from input transfer to out_valid SHALL be exactly 2 cycles when not stalled.
REQ-015 S1 SHALL register x, sel, and one zero flag per 3-bit segment (segment k zero = all 3 bits 0).
REQ-016 S2 SHALL compute a per-segment borrow-select: segment k is decremented iff sel is 1 and all segments below k are zero; segment 0 uses sel directly.
REQ-017 Within a decremented segment s, bit i SHALL toggle iff s[i-1:0] are all 0; bit 0 always toggles, bit 1 when s0 = 0, bit 2 when s0 = 0 and s1 = 0.
REQ-018 Non-decremented segments SHALL pass through unchanged; result SHALL wrap modulo 2^WIDTH.
REQ-019 borrow_out SHALL be 1 iff sel = 1 and every segment zero flag is 1.
REQ-020 S2 SHALL load when S2 is empty or out_ready = 1; S1 SHALL load when S1 is empty or S2 loads; in_ready SHALL equal the S1 load condition.
REQ-021 in_ready SHALL be combinational from stage valids and out_ready only, and SHALL NOT depend on in_valid.
REQ-022 Sustained in_valid = 1 and out_ready = 1 SHALL give one result per cycle.
REQ-023 With out_ready = 0 and both stages full, in_ready SHALL be 0. Stage contents SHALL hold stable, and out_valid/result SHALL NOT change until the transfer completes.
REQ-024 A simultaneous output transfer and input transfer on a full pipe SHALL advance both stages with no bubble and no loss.
REQ-025 A stage whose valid is 0 SHALL NOT assert out_valid; data in empty stages is don't-care internally but SHALL NOT reach result while out_valid = 0.

Reset
REQ-026 While rst = 1 at a rising edge, both stage valid flags SHALL clear; out_valid SHALL be 0 in the following cycle.
REQ-027 After reset, result and borrow_out SHALL read 0, and in_ready SHALL be 1 in the cycle after rst deasserts.
REQ-028 rst asserted mid-stream SHALL discard every in-flight operand, and no result for those operands SHALL be presented after reset.
REQ-029 rst SHALL take priority over any simultaneous transfer.

Structure
REQ-030 SEG = 3 and the default WIDTH SHALL live in the shared package a1csa_pkg, together with the segment count constant WIDTH/SEG.
REQ-031 The per-segment decrement SHALL be one sub-module, rb_dec3 (inputs sel and a 3-bit segment; output the 3-bit decremented segment), instantiated WIDTH/SEG times via generate.
REQ-032 Handshake and stage registers SHALL stay in a1csa_dec_pipe; no other sub-modules.

Verification (WIDTH = 12)
REQ-033 x = 0x010, sel = 1, out_ready = 1 -> 2 cycles later result = 0x00F, borrow_out = 0.
REQ-034 x = 0x000, sel = 1 -> result = 0xFFF, borrow_out = 1; x = 0xABC, sel = 0 -> result = 0xABC, borrow_out = 0.
REQ-035 x = 0x200, sel = 1 (borrow crosses 3 segments) -> result = 0x1FF, borrow_out = 0.
REQ-036 Stream 0x005, 0x040, 0x800 (sel = 1) back-to-back with out_ready = 0 for 2 cycles mid-stream -> in_ready drops to 0, and outputs are 0x004, 0x03F, 0x7FF in order with no loss or duplicate.
REQ-037 Full pipe, then rst = 1 for one cycle -> out_valid = 0 and result = 0 the next cycle; no stale result afterward, and in_ready = 1.
REQ-038 Random x and sel, with random in_valid/out_ready, over 10k transfers -> every result matches (x - sel) mod 4096 and borrow_out matches, in order.
